// File: rtl/wlan_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : wlan_clk_en_gen
// Brief    : PLL lock supervisor with staggered per-channel reset release and
//            NUM_CLOCKS phase-accumulator fractional clock-enable strobes.
// Revision : 1.0  initial release
// ============================================================================
module wlan_clk_en_gen #(
    parameter int NUM_CLOCKS         = 4,
    parameter int ACC_WIDTH          = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_STAGGER        = 16
) (
    input  logic                            refclk,
    input  logic                            rst,
    input  logic                            pll_locked,
    input  logic [NUM_CLOCKS*ACC_WIDTH-1:0] incr,
    input  logic [NUM_CLOCKS-1:0]           ch_en,
    input  logic                            clr_lock_lost,
    output logic [NUM_CLOCKS-1:0]           ce,
    output logic [NUM_CLOCKS-1:0]           ch_rst,
    output logic                            locked,
    output logic                            lock_lost,
    output logic [2:0]                      state
);

    // Last release offset: channel NUM_CLOCKS-1 leaves reset this many
    // cycles after channel 0.
    localparam int c_REL_LAST = (NUM_CLOCKS - 1) * RST_STAGGER;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_cnt;
    logic [31:0]             w_cnt_nxt;
    logic                    w_loss;
    logic [NUM_CLOCKS-1:0]   r_ch_rst;
    logic [NUM_CLOCKS-1:0]   w_ch_rst_nxt;
    logic                    r_locked;
    logic                    r_lock_lost;
    logic                    r_sync1;
    logic                    r_lk_s;

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_lk_s  <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_lk_s  <= r_sync1;
        end
    end

    // Next-state logic; r_cnt is the stability counter in STABLE and the
    // release offset counter in RELEASE.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_loss       = 1'b0;
        w_ch_rst_nxt = '1;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (r_lk_s) begin
                    w_state_nxt = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!r_lk_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == 32'(LOCK_STABLE_CYCLES - 1)) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_RELEASE: begin
                if (!r_lk_s) begin
                    w_loss      = 1'b1;
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if ((NUM_CLOCKS == 1) || (r_cnt + 32'd1 == 32'(c_REL_LAST))) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_RUN: begin
                if (!r_lk_s) begin
                    w_loss      = 1'b1;
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
        // Channel k leaves reset once the release offset reaches k*RST_STAGGER.
        for (int k = 0; k < NUM_CLOCKS; k++) begin
            if (w_state_nxt == ST_RUN) begin
                w_ch_rst_nxt[k] = 1'b0;
            end else if ((w_state_nxt == ST_RELEASE) &&
                         (32'(k * RST_STAGGER) <= w_cnt_nxt)) begin
                w_ch_rst_nxt[k] = 1'b0;
            end
        end
    end

    // State, channel resets, locked and the sticky lock-lost flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_ch_rst    <= '1;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ch_rst <= w_ch_rst_nxt;
            r_locked <= (w_state_nxt == ST_RUN);
            if (w_loss) begin
                r_lock_lost <= 1'b1;
            end else if (clr_lock_lost) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
        logic [ACC_WIDTH-1:0] r_acc;
        logic                 r_ce;
        logic [ACC_WIDTH:0]   w_sum;

        assign w_sum = {1'b0, r_acc} + {1'b0, incr[i*ACC_WIDTH +: ACC_WIDTH]};

        // Phase accumulator; the carry-out becomes this channel's strobe.
        always_ff @(posedge refclk) begin
            if (rst || w_loss) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (!r_ch_rst[i] && ch_en[i]) begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
                r_ce  <= w_sum[ACC_WIDTH];
            end else begin
                r_ce  <= 1'b0;
            end
        end

        assign ce[i] = r_ce;
    end

    assign ch_rst    = r_ch_rst;
    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;
    assign state     = r_state;

endmodule
`default_nettype wire
